// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (port 0) and
// the debug/loader path (port 1). Define DMEM_ARB_PERF_EN for grant/stall counters.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_WIDTH     = 32,
  parameter int MEM_DEPTH     = 100,
  parameter int MAX_LOCK      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  // Handshake (both ports): the requester raises req with we/addr/wdata and holds
  // them stable until it sees gnt. gnt is combinational and completes the access
  // in that same cycle; read data comes back one cycle later with rvalid.
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [MEM_WIDTH-1:0]     p0_wdata,
  input  logic                     p0_lock,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic [MEM_WIDTH-1:0]     p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [MEM_WIDTH-1:0]     p1_wdata,
  input  logic                     p1_lock,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic [MEM_WIDTH-1:0]     p1_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic                     mem_WE,
  output logic [MEM_WIDTH-1:0]     mem_WD,
  input  logic [MEM_WIDTH-1:0]     mem_RD,
  output logic                     addr_err,
  // FSM state: 0 = IDLE, 1 = OWN0, 2 = OWN1
  output logic [1:0]               dbg_state
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]              p0_gnt_cnt,
  output logic [15:0]              p1_gnt_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH = ADDRESS_WIDTH'(MEM_DEPTH);

  state_t         state, state_nxt;
  logic [CW-1:0]  lock_cnt, lock_cnt_nxt, cnt_inc;
  logic           last_win, last_win_nxt;   // 1: port 1 won most recently
  logic           gnt0, gnt1;
  logic           pick0_idle, pick1_idle;
  logic           cnt_below_max;
  logic           in_range0, in_range1;

  assign in_range0     = (p0_addr < DEPTH);
  assign in_range1     = (p1_addr < DEPTH);
  assign cnt_below_max = (lock_cnt < LOCK_MAX);
  assign cnt_inc       = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + CNT_ONE;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign dbg_state = state;

  // Grant decision. An owner past its lock budget yields only if the other port wants the slot.
  always_comb begin
    pick0_idle = p0_req & (~p1_req | last_win);
    pick1_idle = p1_req & (~p0_req | ~last_win);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      OWN0: begin
        if (p0_req && p0_lock) begin
          if (cnt_below_max || !p1_req) gnt0 = 1'b1;
          else                          gnt1 = 1'b1;
        end else begin
          gnt0 = pick0_idle;
          gnt1 = pick1_idle;
        end
      end
      OWN1: begin
        if (p1_req && p1_lock) begin
          if (cnt_below_max || !p0_req) gnt1 = 1'b1;
          else                          gnt0 = 1'b1;
        end else begin
          gnt0 = pick0_idle;
          gnt1 = pick1_idle;
        end
      end
      default: begin
        gnt0 = pick0_idle;
        gnt1 = pick1_idle;
      end
    endcase
    // Requests seen in the reset cycle are dropped rather than performed.
    if (RST) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Ownership follows the granted port's lock; the counter includes the entering grant.
  always_comb begin
    state_nxt    = IDLE;
    lock_cnt_nxt = '0;
    last_win_nxt = last_win;
    if (gnt0) begin
      last_win_nxt = 1'b0;
      if (p0_lock) begin
        state_nxt    = OWN0;
        lock_cnt_nxt = (state == OWN0) ? cnt_inc : CNT_ONE;
      end
    end else if (gnt1) begin
      last_win_nxt = 1'b1;
      if (p1_lock) begin
        state_nxt    = OWN1;
        lock_cnt_nxt = (state == OWN1) ? cnt_inc : CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last_win <= 1'b1;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      last_win <= last_win_nxt;
    end
  end

  always_comb begin
    mem_A  = '0;
    mem_WE = 1'b0;
    mem_WD = '0;
    if (gnt0) begin
      mem_A  = p0_addr;
      mem_WE = p0_we & in_range0;
      mem_WD = p0_wdata;
    end else if (gnt1) begin
      mem_A  = p1_addr;
      mem_WE = p1_we & in_range1;
      mem_WD = p1_wdata;
    end
  end

  // Out-of-range reads return zero instead of whatever the memory drives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      addr_err  <= 1'b0;
    end else begin
      p0_rvalid <= gnt0 & ~p0_we;
      p1_rvalid <= gnt1 & ~p1_we;
      if (gnt0 && !p0_we) p0_rdata <= in_range0 ? mem_RD : '0;
      if (gnt1 && !p1_we) p1_rdata <= in_range1 ? mem_RD : '0;
      addr_err  <= (gnt0 & ~in_range0) | (gnt1 & ~in_range1);
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic stall;
  assign stall = (p0_req & ~gnt0) | (p1_req & ~gnt1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      p0_gnt_cnt <= '0;
      p1_gnt_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (gnt0 && p0_gnt_cnt != 16'hFFFF) p0_gnt_cnt <= p0_gnt_cnt + 16'd1;
      if (gnt1 && p1_gnt_cnt != 16'hFFFF) p1_gnt_cnt <= p1_gnt_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt  <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue/array-level model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 100;
  localparam int MAXL  = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_A;
  logic          mem_WE, addr_err;
  logic [DW-1:0] mem_WD, mem_RD;
  logic [1:0]    dbg_state;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   p0_gnt_cnt, p1_gnt_cnt, stall_cnt;
`endif

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .MEM_WIDTH(DW), .MEM_DEPTH(DEPTH), .MAX_LOCK(MAXL)) dut (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
    .addr_err(addr_err), .dbg_state(dbg_state)
`ifdef DMEM_ARB_PERF_EN
    , .p0_gnt_cnt(p0_gnt_cnt), .p1_gnt_cnt(p1_gnt_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Memory seen by the DUT; out-of-range addresses drive a junk pattern.
  logic [DW-1:0] sram [DEPTH];
  assign mem_RD = (mem_A < AW'(DEPTH)) ? sram[int'(mem_A)] : 32'hA5A5_A5A5;
  always @(posedge CLK) if (mem_WE && mem_A < AW'(DEPTH)) sram[int'(mem_A)] <= mem_WD;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_valid = 1'b0;
  int            m_owner;            // -1 none, else owning port
  int            m_run;              // consecutive grants held by the owner
  int            m_last;             // port that won most recently
  bit            m_g0, m_g1;         // model grants of the cycle just finished
  bit            e_rv0, e_rv1, e_err;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [DW-1:0] exp_q[$];           // expected p1 read data in directed test

  function automatic int pick(bit r0, bit r1, bit l0, bit l1);
    bit r[2];
    bit l[2];
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    if (m_owner >= 0 && r[m_owner] && l[m_owner] && (m_run < MAXL || !r[1 - m_owner]))
      return m_owner;
    if (r0 && r1) return 1 - m_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  int            w;
  logic [AW-1:0] xa;
  logic [DW-1:0] xd;
  bit            xw, xl, inr;

  always @(negedge CLK) begin
    if (RST) begin
      if (m_valid) begin
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_mem_WE", mem_WE, 0);
      end
      m_valid = 1'b1;
      m_owner = -1; m_run = 0; m_last = 1;
      m_g0 = 1'b0; m_g1 = 1'b0;
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rd0 = '0; e_rd1 = '0;
    end else if (m_valid) begin
      chk("p0_rvalid", p0_rvalid, e_rv0);
      chk("p0_rdata",  p0_rdata,  e_rd0);
      chk("p1_rvalid", p1_rvalid, e_rv1);
      chk("p1_rdata",  p1_rdata,  e_rd1);
      chk("addr_err",  addr_err,  e_err);
      w = pick(p0_req, p1_req, p0_lock, p1_lock);
      if (w == 0)      begin xa = p0_addr; xw = p0_we; xd = p0_wdata; xl = p0_lock; end
      else if (w == 1) begin xa = p1_addr; xw = p1_we; xd = p1_wdata; xl = p1_lock; end
      else             begin xa = '0;      xw = 1'b0;  xd = '0;       xl = 1'b0;    end
      inr = (xa < AW'(DEPTH));
      chk("p0_gnt", p0_gnt, (w == 0));
      chk("p1_gnt", p1_gnt, (w == 1));
      chk("mem_A",  mem_A,  xa);
      chk("mem_WE", mem_WE, xw && inr);
      chk("mem_WD", mem_WD, xd);
      e_err = (w >= 0) && !inr;
      e_rv0 = (w == 0) && !xw;
      e_rv1 = (w == 1) && !xw;
      if (e_rv0) e_rd0 = inr ? ref_mem[int'(xa)] : '0;
      if (e_rv1) e_rd1 = inr ? ref_mem[int'(xa)] : '0;
      if (w >= 0 && xw && inr) ref_mem[int'(xa)] = xd;
      if (w >= 0) begin
        if (xl) begin
          m_run   = (m_owner == w) ? ((m_run < MAXL) ? m_run + 1 : MAXL) : 1;
          m_owner = w;
        end else begin
          m_owner = -1; m_run = 0;
        end
        m_last = w;
      end else begin
        m_owner = -1; m_run = 0;
      end
      m_g0 = (w == 0);
      m_g1 = (w == 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv0(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
    p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; p0_lock = l;
  endtask

  task automatic drv1(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
    p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = l;
  endtask

  task automatic rand_port(input int p);
    bit r, we, l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r  = ($urandom_range(0, 99) < 65);
    we = 1'($urandom_range(0, 1));
    a  = AW'($urandom_range(0, 109));
    d  = $urandom;
    l  = ($urandom_range(0, 99) < 35);
    if (p == 0) drv0(r, we, a, d, l);
    else        drv1(r, we, a, d, l);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    int run1;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    RST = 1'b1;
    drv0(0, 0, '0, '0, 0);
    drv1(0, 0, '0, '0, 0);
    step();
    step();
    RST = 1'b0;
    #1;
    chk("dbg_state_idle_after_reset", dbg_state, 2'd0);
    chk("p0_rvalid_after_reset", p0_rvalid, 0);
    chk("addr_err_after_reset", addr_err, 0);

    // Write then read-back across ports
    drv0(1, 1, 5, 32'hDEAD_BEEF, 0);
    #1;
    chk("t1_p0_gnt", p0_gnt, 1);
    chk("t1_mem_WE", mem_WE, 1);
    chk("t1_mem_A",  mem_A,  5);
    step();
    drv0(0, 0, '0, '0, 0);
    drv1(1, 0, 5, '0, 0);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("t1_p1_gnt", p1_gnt, 1);
    step();
    drv1(0, 0, '0, '0, 0);
    chk("t1_p1_rvalid", p1_rvalid, 1);
    chk("t1_p1_rdata",  p1_rdata,  exp_q.pop_front());

    // Round robin with both ports reading continuously
    step();
    drv0(1, 0, 10, '0, 0);
    drv1(1, 0, 11, '0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_p0_alt", p0_gnt, (i % 2 == 0));
      chk("t2_p1_alt", p1_gnt, (i % 2 == 1));
      step();
    end
    drv0(0, 0, '0, '0, 0);
    drv1(0, 0, '0, '0, 0);
    step();

    // Port 1 locks for 20 cycles against a competing port 0
    drv1(1, 0, 20, '0, 1);
    run1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) drv0(1, 0, 21, '0, 0);
      #1;
      chk("t3_p1_lock", p1_gnt, !(i == 8 || i == 17));
      if (p1_gnt) run1++;
      else if (i == 8) begin
        chk("t3_p1_run_len", run1, MAXL);
        run1 = 0;
      end
      step();
    end
    drv0(0, 0, '0, '0, 0);
    drv1(0, 0, '0, '0, 0);
    step();

    // Out-of-range write and read
    drv0(1, 1, 100, 32'h1234, 0);
    #1;
    chk("t4_p0_gnt", p0_gnt, 1);
    chk("t4_mem_WE", mem_WE, 0);
    step();
    chk("t4_addr_err_w", addr_err, 1);
    chk("t4_no_rvalid_w", p0_rvalid, 0);
    drv0(1, 0, 100, '0, 0);
    step();
    drv0(0, 0, '0, '0, 0);
    chk("t4_rvalid_r", p0_rvalid, 1);
    chk("t4_rdata_r", p0_rdata, 0);
    chk("t4_addr_err_r", addr_err, 1);
    step();

    // Reset right after a read grant
    drv0(1, 0, 5, '0, 0);
    step();
    drv0(0, 0, '0, '0, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5_rvalid_cleared", p0_rvalid, 0);
    chk("t5_rdata_cleared", p0_rdata, 0);
    drv0(1, 0, 30, '0, 0);
    drv1(1, 0, 31, '0, 0);
    #1;
    chk("t5_first_tie_p0", p0_gnt, 1);
    step();
    drv0(0, 0, '0, '0, 0);
    drv1(0, 0, '0, '0, 0);
    step();

    // Random traffic; a waiting requester keeps its request stable
    for (int c = 0; c < 3000; c++) begin
      if (!(p0_req && !m_g0)) rand_port(0);
      else p0_lock = ($urandom_range(0, 99) < 35);
      if (!(p1_req && !m_g1)) rand_port(1);
      else p1_lock = ($urandom_range(0, 99) < 35);
      RST = ($urandom_range(0, 299) == 0);
      step();
    end
    RST = 1'b0;
    drv0(0, 0, '0, '0, 0);
    drv1(0, 0, '0, '0, 0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory between two requesters.
- Port 0 is the core load/store path. Port 1 is the debug/loader path used to preload or inspect memory.
- Grants one access per cycle, drives the memory address/write-enable/write-data lines, and returns registered read data to the granted requester.
- Round-robin fairness, bounded bus locking for back-to-back transfers, and out-of-range address protection.

Parameters:
- ADDRESS_WIDTH, 32, width of requester and memory addresses
- MEM_WIDTH, 32, data word width
- MEM_DEPTH, 100, number of valid words; addresses >= MEM_DEPTH are out of range
- MAX_LOCK, 8, maximum consecutive grants a locking port may hold while the other port is requesting (>=1)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous active-high reset
- p0_req  input  1  port 0 access request
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDRESS_WIDTH  port 0 word address
- p0_wdata  input  MEM_WIDTH  port 0 write data
- p0_lock  input  1  port 0 requests to keep ownership next cycle
- p0_gnt  output  1  port 0 access performed this cycle
- p0_rvalid  output  1  port 0 read data valid
- p0_rdata  output  MEM_WIDTH  port 0 read data
- p1_*  same set as p0_*, for port 1
- mem_A  output  ADDRESS_WIDTH  memory address
- mem_WE  output  1  memory write enable
- mem_WD  output  MEM_WIDTH  memory write data
- mem_RD  input  MEM_WIDTH  memory asynchronous read data
- addr_err  output  1  pulse: granted access was out of range

Behaviour:
- Reset: RST sampled high at a rising CLK edge puts all registers in reset.
  - State becomes IDLE, lock counter 0, last-winner pointer = 1 (port 0 wins the first tie).
  - p0/p1_rvalid = 0, p0/p1_rdata = 0, addr_err = 0.
  - Reset has priority over any in-flight request; a request present in the reset cycle is dropped, not deferred.
- Grant is combinational in the same cycle as the request.
  - At most one of p0_gnt/p1_gnt is high. gnt = 0 whenever req = 0.
  - A requester must hold req, we, addr and wdata stable until it sees gnt.
- Memory drive:
  - mem_A/mem_WD are muxed from the granted port.
  - mem_WE = granted port's we AND address in range.
  - With no grant: mem_A = 0, mem_WE = 0, mem_WD = 0.
- FSM states:
  - IDLE: no owner. Both requesting -> grant the port opposite the last-winner pointer. One requesting -> grant it.
  - OWN0 / OWN1: entered when the granted port had lock=1.
    - The owner wins unconditionally while it keeps req=1 and lock=1 and the lock counter < MAX_LOCK.
    - Leave to IDLE-rule arbitration when the owner drops req or lock.
    - Also leave when the counter reaches MAX_LOCK while the other port requests; the other port then wins that cycle.
    - If the other port is idle, the counter saturates and ownership continues.
- Lock counter: counts consecutive owner grants. It clears on any change of owner or entry to IDLE.
- Last-winner pointer updates on every grant.
- Read response (1-cycle latency):
  - A granted read registers mem_RD into px_rdata.
  - px_rvalid pulses high for exactly one cycle after the grant cycle.
  - rdata holds its value until the next read response for that port.
- Out of range (addr >= MEM_DEPTH):
  - The access is still granted and consumes the slot.
  - Writes are suppressed.
  - A read returns rvalid with rdata = 0.
  - addr_err pulses one cycle after the grant, aligned with rvalid for reads.
- Writes produce no rvalid.
- Simultaneous read by one port and write by the other: only the granted access occurs. The loser waits; there is no bypass.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, adds outputs p0_gnt_cnt, p1_gnt_cnt and stall_cnt, each 16 bits:
  - px_gnt_cnt counts grants per port.
  - stall_cnt counts cycles where a requester had req=1 and gnt=0.
  - All three saturate at 16'hFFFF and are cleared by RST.
- When not defined, these ports and registers do not exist, and the behaviour above is unchanged.

Test Plan:
- Reset, then p0 writes 0xDEADBEEF to addr 5 while p1 is idle -> p0_gnt=1 same cycle, mem_WE=1, mem_A=5; a p1 read of addr 5 next cycle -> p1_rvalid one cycle later with p1_rdata=0xDEADBEEF.
- Both ports request reads continuously with lock=0 -> grants alternate p0,p1,p0,p1 starting with p0 after reset; each rvalid follows its grant by one cycle.
- p1 holds req+lock for 20 cycles while p0 also requests, MAX_LOCK=8 -> p1 gets 8 consecutive grants, then p0 gets 1, then p1 resumes.
- p0 writes 0x1234 to addr 100 (MEM_DEPTH=100) -> p0_gnt=1, mem_WE=0, addr_err pulses next cycle; a read of addr 100 -> p0_rdata=0, p0_rvalid=1, addr_err=1.
- RST asserted in the cycle after a p0 read grant -> p0_rvalid=0, p0_rdata=0 after that edge; first arbitration after reset favours p0.
